// File: rtl/fp_to_int.sv
// Converts a 13-bit float (1/4/8, implicit leading 1) to an 8-bit sign-magnitude
// integer by truncation, using a one-bit-per-cycle shifter with a valid/ready handshake.
module fp_to_int #(
    parameter int EXP_BIAS = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [12:0] i_float,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_int,
    output logic        o_overflow,
    output logic        o_valid,
    input  logic        i_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [4:0] EXP_MIN   = 5'(EXP_BIAS);
    localparam logic [4:0] EXP_SAT   = 5'(EXP_BIAS + 7);
    localparam logic [4:0] SHIFT_TOP = 5'(EXP_BIAS + 8);

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic [8:0] shift_r;
    logic [3:0] cnt_r;
    logic       sign_r;
    logic [4:0] exp_s;
    logic       small_s;
    logic       sat_s;
    logic [4:0] shamt_s;

    // Operand classification: below one, saturating, or needing the shifter
    always_comb begin
        exp_s   = {1'b0, i_float[11:8]};
        small_s = (exp_s < EXP_MIN);
        sat_s   = (exp_s >= EXP_SAT);
        shamt_s = SHIFT_TOP - exp_s;
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    if (small_s || sat_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            shift_r    <= 9'd0;
            cnt_r      <= 4'd0;
            sign_r     <= 1'b0;
            o_int      <= 8'h00;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
        end else begin
            state_r <= state_s;
            o_ready <= (state_s == IDLE);
            o_valid <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        sign_r <= i_float[12];
                        if (small_s) begin
                            o_int      <= {i_float[12], 7'd0};
                            o_overflow <= 1'b0;
                        end else if (sat_s) begin
                            o_int      <= {i_float[12], 7'h7F};
                            o_overflow <= 1'b1;
                        end else begin
                            shift_r    <= {1'b1, i_float[7:0]};
                            cnt_r      <= shamt_s[3:0];
                            o_overflow <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    shift_r <= {1'b0, shift_r[8:1]};
                    cnt_r   <= cnt_r - 4'd1;
                    // Final shift lands here; the result always fits in 7 bits
                    if (cnt_r <= 4'd1) begin
                        o_int      <= {sign_r, shift_r[7:1]};
                        o_overflow <= 1'b0;
                    end
                end
                DONE: begin
                    shift_r <= shift_r;
                end
                default: begin
                    shift_r <= 9'd0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: accepted operands push a real-arithmetic expectation,
// a negedge monitor pops and checks value, overflow flag, arrival cycle and hold behaviour.
module tb_fp_to_int;

    localparam int BIAS = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] flt = 13'd0;
    logic        vin = 1'b0;
    logic        rdy_out;
    logic [7:0]  res;
    logic        ovf;
    logic        vout;
    logic        rdy_in = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [7:0] v;
        logic       o;
        int         at;
    } exp_t;
    exp_t q[$];

    fp_to_int #(.EXP_BIAS(BIAS)) dut (
        .i_clk(clk), .i_rst(rst), .i_float(flt), .i_valid(vin),
        .o_ready(rdy_out), .o_int(res), .o_overflow(ovf), .o_valid(vout),
        .i_ready(rdy_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Value = 1.fraction * 2^(e-bias), truncated; anything >= 128 saturates.
    function automatic exp_t model(input logic [12:0] f, input int c);
        exp_t r;
        int e;
        real m;
        int mag;
        e = int'(f[11:8]);
        m = real'(256 + int'(f[7:0])) * (2.0 ** (e - BIAS)) / 256.0;
        mag = int'($floor(m));
        if (mag > 127) begin
            r.v = {f[12], 7'h7F};
            r.o = 1'b1;
        end else begin
            r.v = {f[12], 7'(mag)};
            r.o = 1'b0;
        end
        if (e < BIAS || mag > 127) r.at = c + 1;
        else r.at = c + 1 + (8 + BIAS - e);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Issue side of the scoreboard: an accepted operand pushes its expectation
    always @(negedge clk) begin
        if (rst) q.delete();
        else if (vin && rdy_out) q.push_back(model(flt, cyc));
    end

    logic       prev_v = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] held_v;
    logic       held_o;

    // Monitor: pop on each new result, check hold stability and one-cycle pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hs) begin
                chk("valid_drops_after_handshake", int'(vout), 0);
            end else if (vout && prev_v) begin
                chk("hold_int", int'(res), int'(held_v));
                chk("hold_ovf", int'(ovf), int'(held_o));
            end else if (vout) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", int'(res), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("o_int", int'(res), int'(e.v));
                    chk("o_overflow", int'(ovf), int'(e.o));
                    chk("valid_cycle", cyc, e.at);
                end
                held_v = res;
                held_o = ovf;
            end
            if (vout) chk("ready_low_in_done", int'(rdy_out), 0);
            prev_v  = vout;
            prev_hs = vout && rdy_in;
        end else begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy_in = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [12:0] f);
        int n;
        flt = f;
        vin = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy_out && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", n, 0);
        tick();
        vin = 1'b0;
        flt = 13'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !rdy_out) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("drain_timeout", n, 0);
    endtask

    logic [12:0] dir [6] = '{13'h0700, 13'h1DFC, 13'h0860, 13'h0600, 13'h1000, 13'h0F00};

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(rdy_out), 1);
        chk("rst_valid", int'(vout), 0);
        chk("rst_int", int'(res), 0);
        chk("rst_ovf", int'(ovf), 0);
        tick();

        for (int i = 0; i < 6; i++) begin
            send(dir[i]);
            drain();
        end

        // Backpressure: result held for 5 cycles while junk operands are offered
        rdy_in = 1'b0;
        send(13'h0860);
        n = 0;
        while (!vout && n < 20) begin
            tick();
            n++;
        end
        chk("bp_reached_done", int'(vout), 1);
        for (int i = 0; i < 5; i++) begin
            vin = i[0];
            flt = 13'h0F00;
            tick();
        end
        vin = 1'b0;
        rdy_in = 1'b1;
        drain();
        send(13'h0700);
        drain();

        // Reset in the middle of a shift: the operation must vanish
        send(13'h0700);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(rdy_out), 1);
        chk("midrst_valid", int'(vout), 0);
        repeat (12) tick();

        // Back-to-back with i_valid held high between the two operands
        send(13'h0D00);
        send(13'h0700);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(13'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_rdy = 1'b0;
        rdy_in = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
